uart_rx_fifo: RTL

//  Parametrised UART receive engine with a receive FIFO; successor to the fixed-format SOPC_CORE receive path.

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_rx_fifo_if.sv | 24 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_rx_fifo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: baud divisor table,
// receiver state encoding and FIFO word width.
package uart_pkg;

    localparam int unsigned FIFO_W = 10;
    localparam int unsigned DIV_W  = 24;

    typedef logic [15:0][DIV_W-1:0] div_tab_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRKWAIT
    } rx_state_t;

    function automatic int unsigned baud_rate(input int unsigned sel);
        case (sel)
            0:       baud_rate = 300;
            1:       baud_rate = 1200;
            2:       baud_rate = 2400;
            3:       baud_rate = 4800;
            4:       baud_rate = 9600;
            5:       baud_rate = 19200;
            6:       baud_rate = 38400;
            7:       baud_rate = 57600;
            8:       baud_rate = 115200;
            9:       baud_rate = 230400;
            10:      baud_rate = 460800;
            default: baud_rate = 921600;
        endcase
    endfunction

    // Clocks per bit for every baudm code; codes 12..15 reuse the fastest rate.
    function automatic div_tab_t div_table(input int unsigned clk_hz);
        div_tab_t t;
        t = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            t[i] = DIV_W'(clk_hz / baud_rate(i));
        end
        return t;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU-side read port of the UART receiver: pop strobe, head word, FIFO status and overrun flag.
interface uart_rx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 16
) ();
    logic                              rd;
    logic                              err_clr;
    logic [7:0]                        rdata;
    logic                              rperr;
    logic                              rferr;
    logic                              empty;
    logic                              full;
    logic [$clog2(FIFO_DEPTH+1)-1:0]   count;
    logic                              oerr;

    modport master (
        output rd, err_clr,
        input  rdata, rperr, rferr, empty, full, count, oerr
    );

    modport slave (
        input  rd, err_clr,
        output rdata, rperr, rferr, empty, full, count, oerr
    );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head word visible whenever not empty, reads as zero when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             pop_ok;
    logic             push_ok;

    // A push into a full FIFO still lands when the same cycle frees a slot.
    assign pop_ok  = pop && (cnt != '0);
    assign push_ok = push && ((cnt != CW'(DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with run-time frame format and a show-ahead receive FIFO.
// Optional break detection is compiled in with UART_RX_BREAK_DET_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  baudm,
    input  logic        bit8,
    input  logic        pen,
    input  logic        ohel,
    input  logic        rx,
`ifdef UART_RX_BREAK_DET_EN
    output logic        brk,
`endif
    uart_rx_fifo_if.slave bus
);
    localparam div_tab_t    DIV = div_table(CLK_HZ);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH+1);

    logic [SYNC_STAGES-1:0] rx_sync;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   fall;

    rx_state_t              state;
    logic [DIV_W-1:0]       timer;
    logic [DIV_W-1:0]       bit_k;
    logic [2:0]             bit_idx;
    logic [7:0]             rx_data;
    logic                   perr;
    logic                   cfg_bit8;
    logic                   cfg_pen;
    logic                   cfg_ohel;
    logic                   push;
    logic [FIFO_W-1:0]      push_word;

    logic [FIFO_W-1:0]      fifo_rdata;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [CW-1:0]          fifo_count;
    logic                   oerr;
    logic [2:0]             last_idx;
    logic                   tc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync <= '1;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx};
            rx_prev <= rx_s;
        end
    end

    assign rx_s     = rx_sync[SYNC_STAGES-1];
    assign fall     = rx_prev && !rx_s;
    assign tc       = (timer == '0);
    assign last_idx = cfg_bit8 ? 3'd7 : 3'd6;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            bit_k     <= '0;
            bit_idx   <= '0;
            rx_data   <= '0;
            perr      <= 1'b0;
            cfg_bit8  <= 1'b0;
            cfg_pen   <= 1'b0;
            cfg_ohel  <= 1'b0;
            push      <= 1'b0;
            push_word <= '0;
`ifdef UART_RX_BREAK_DET_EN
            brk       <= 1'b0;
`endif
        end else begin
            push <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fall) begin
                        bit_k    <= DIV[baudm];
                        timer    <= (DIV[baudm] >> 1) - DIV_W'(1);
                        cfg_bit8 <= bit8;
                        cfg_pen  <= pen;
                        cfg_ohel <= ohel;
                        rx_data  <= '0;
                        bit_idx  <= '0;
                        perr     <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (!tc) begin
                        timer <= timer - DIV_W'(1);
                    end else if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        timer <= bit_k - DIV_W'(1);
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (!tc) begin
                        timer <= timer - DIV_W'(1);
                    end else begin
                        rx_data[bit_idx] <= rx_s;
                        timer            <= bit_k - DIV_W'(1);
                        if (bit_idx == last_idx) begin
                            state <= cfg_pen ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (!tc) begin
                        timer <= timer - DIV_W'(1);
                    end else begin
                        perr  <= rx_s != (cfg_ohel ? ~^rx_data : ^rx_data);
                        timer <= bit_k - DIV_W'(1);
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (!tc) begin
                        timer <= timer - DIV_W'(1);
                    end else begin
                        state <= IDLE;
`ifdef UART_RX_BREAK_DET_EN
                        if (!rx_s && (rx_data == '0)) begin
                            brk   <= 1'b1;
                            state <= BRKWAIT;
                        end else begin
                            push      <= 1'b1;
                            push_word <= {perr, !rx_s, rx_data};
                        end
`else
                        push      <= 1'b1;
                        push_word <= {perr, !rx_s, rx_data};
`endif
                    end
                end
                BRKWAIT: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_word),
        .pop   (bus.rd),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Overrun only when the word is actually lost; a simultaneous set beats err_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oerr <= 1'b0;
        end else if (push && fifo_full && !bus.rd) begin
            oerr <= 1'b1;
        end else if (bus.err_clr) begin
            oerr <= 1'b0;
        end
    end

    assign bus.rperr = fifo_rdata[9];
    assign bus.rferr = fifo_rdata[8];
    assign bus.rdata = fifo_rdata[7:0];
    assign bus.empty = fifo_empty;
    assign bus.full  = fifo_full;
    assign bus.count = fifo_count;
    assign bus.oerr  = oerr;

endmodule
